// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA bus responder slice.
package dma_pkg;

  localparam int DMA_ADDR_W = 16;
  localparam int DATA_W     = 8;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    WAIT    = 4'b0010,
    GRANT   = 4'b0100,
    RELEASE = 4'b1000
  } holdState_t;

  // True for a legal single-strobe memory cycle while the bus is held by DMA.
  function automatic logic isAccess(input logic aen, input logic hlda,
                                    input logic memr_n, input logic memw_n);
    return aen && hlda && (memr_n != memw_n);
  endfunction

endpackage

// File: rtl/dma_bus_responder_if.sv
// System-bus signals shared between the DMA controller (master) and the responder (slave).
interface dma_bus_responder_if;
  import dma_pkg::*;

  logic              HRQ;
  logic              cpuBusy;
  logic              HLDA;
  logic              AEN;
  logic              ADSTB;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] DB_in;
  logic [DATA_W-1:0] DB_out;
  logic              DB_oe;
  logic              MEMR_N;
  logic              MEMW_N;
  logic              EOP_N;
  logic              eopSeen;
  logic              protocolError;
  logic [15:0]       readCount;
  logic [15:0]       writeCount;

  modport master (
    output HRQ, cpuBusy, AEN, ADSTB, A, DB_in, MEMR_N, MEMW_N, EOP_N,
    input  HLDA, DB_out, DB_oe, eopSeen, protocolError, readCount, writeCount
  );

  modport slave (
    input  HRQ, cpuBusy, AEN, ADSTB, A, DB_in, MEMR_N, MEMW_N, EOP_N,
    output HLDA, DB_out, DB_oe, eopSeen, protocolError, readCount, writeCount
  );

endinterface

// File: rtl/dma_resp_mem.sv
// Single-port byte RAM with registered read; contents are never reset.
module dma_resp_mem
  import dma_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dma_bus_responder.sv
// Hold-handshake arbiter plus byte-wide memory target for DMA-issued bus cycles.
module dma_bus_responder
  import dma_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int GRANT_DELAY = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  dma_bus_responder_if.slave  bus
);

  localparam logic [3:0] DELAY_LOAD = 4'(GRANT_DELAY - 1);

  holdState_t             state_reg, state_next;
  logic [3:0]             delay_reg, delay_next;
  logic                   hlda;
  logic                   read_req, write_req, strobe_low, proto_violation;
  logic                   db_oe_reg, eop_reg, perr_reg, memw_n_prev_reg;
  logic [DATA_W-1:0]      upper_reg;
  logic [15:0]            rd_cnt_reg, wr_cnt_reg;
  logic [ADDR_BITS-1:0]   mem_addr;
  logic [DATA_W-1:0]      mem_rdata;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= IDLE;
      delay_reg <= '0;
    end else begin
      state_reg <= state_next;
      delay_reg <= delay_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    delay_next = delay_reg;
    case (state_reg)
      IDLE: begin
        if (bus.HRQ) begin
          state_next = WAIT;
          delay_next = DELAY_LOAD;
        end
      end
      WAIT: begin
        if (!bus.HRQ)             state_next = IDLE;
        else if (bus.cpuBusy)     delay_next = DELAY_LOAD;
        else if (delay_reg == '0) state_next = GRANT;
        else                      delay_next = delay_reg - 4'd1;
      end
      GRANT:   if (!bus.HRQ) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoded from the state register so an asynchronous reset drops HLDA at once.
  assign hlda = (state_reg == GRANT);

  assign read_req   = isAccess(bus.AEN, hlda, bus.MEMR_N, bus.MEMW_N) && !bus.MEMR_N;
  assign write_req  = isAccess(bus.AEN, hlda, bus.MEMR_N, bus.MEMW_N) && !bus.MEMW_N;
  assign strobe_low = !bus.MEMR_N || !bus.MEMW_N;
  assign proto_violation = (!bus.MEMR_N && !bus.MEMW_N)
                        || (strobe_low && (!hlda || !bus.AEN))
                        || (bus.ADSTB && !bus.MEMR_N);

  // Same-cycle accesses see the upper byte latched before this edge.
  assign mem_addr = ADDR_BITS'({upper_reg, bus.A});

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      db_oe_reg       <= 1'b0;
      upper_reg       <= '0;
      eop_reg         <= 1'b0;
      perr_reg        <= 1'b0;
      rd_cnt_reg      <= '0;
      wr_cnt_reg      <= '0;
      memw_n_prev_reg <= 1'b1;
    end else begin
      db_oe_reg <= read_req;
      if (hlda && bus.AEN && bus.ADSTB) upper_reg <= bus.DB_in;
      // Leaving GRANT clears the sticky flag so the next grant starts fresh.
      eop_reg <= hlda && bus.HRQ && (eop_reg || !bus.EOP_N);
      if (proto_violation) perr_reg <= 1'b1;
      if (db_oe_reg && bus.MEMR_N) rd_cnt_reg <= rd_cnt_reg + 16'd1;
      if (write_req && memw_n_prev_reg) wr_cnt_reg <= wr_cnt_reg + 16'd1;
      memw_n_prev_reg <= bus.MEMW_N;
    end
  end

  dma_resp_mem #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .clk   (CLK),
    .we    (write_req),
    .addr  (mem_addr),
    .wdata (bus.DB_in),
    .rdata (mem_rdata)
  );

  assign bus.HLDA          = hlda;
  assign bus.DB_oe         = db_oe_reg;
  assign bus.DB_out        = db_oe_reg ? mem_rdata : '0;
  assign bus.eopSeen       = eop_reg;
  assign bus.protocolError = perr_reg;
  assign bus.readCount     = rd_cnt_reg;
  assign bus.writeCount    = wr_cnt_reg;

endmodule

// File: doc/dma_bus_responder.md
# dma_bus_responder

System-bus responder on the far side of the DMA controller: arbitrates the hold handshake (HRQ in, HLDA out) against a CPU bus owner. It latches the upper address byte strobed on DB by ADSTB and serves as the byte-wide memory target for MEMR_N/MEMW_N cycles issued during DMA transfers. It sits on the same bus interface the DMA controller drives and is the stimulus/response partner for controller-level benches.

## Interface
- ADDR_BITS, 10: implemented memory address width; memory holds 2**ADDR_BITS bytes; uses the low ADDR_BITS of the 16-bit DMA address.
- GRANT_DELAY, 2: cycles HRQ must be seen with the CPU idle before HLDA rises (1..15).
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- HRQ  in  1  hold request from DMA controller.
- cpuBusy  in  1  CPU currently owns the bus mid-cycle; no grant while high.
- HLDA  out  1  hold acknowledge.
- AEN  in  1  DMA address enable.
- ADSTB  in  1  upper-address strobe.
- A  in  8  lower address A7..A0.
- DB_in  in  8  data bus input.
- DB_out  out  8  data bus drive value.
- DB_oe  out  1  data bus output enable.
- MEMR_N  in  1  memory read strobe, active low.
- MEMW_N  in  1  memory write strobe, active low.
- EOP_N  in  1  end of process, active low.
- eopSeen  out  1  sticky: EOP_N sampled low during current grant.
- protocolError  out  1  sticky: illegal bus cycle detected.
- readCount  out  16  completed memory reads since reset.
- writeCount  out  16  memory write cycles since reset.

## Operation
- Hold FSM states: IDLE, WAIT, GRANT, RELEASE.
- IDLE: HRQ=1 -> WAIT, delay counter loaded with GRANT_DELAY-1.
- WAIT: HRQ=0 -> IDLE. cpuBusy=1 reloads the counter. Counter==0 with cpuBusy=0 -> GRANT; otherwise decrement.
- GRANT: HLDA=1. HRQ=0 -> RELEASE.
- RELEASE: HLDA=0, eopSeen cleared, upper-address latch kept -> IDLE. HRQ re-asserted in RELEASE is not serviced before IDLE.
- Address latch: in GRANT, ADSTB=1 and AEN=1 loads upperAddr <= DB_in. Effective address = {upperAddr, A}[ADDR_BITS-1:0].
- Read: in GRANT, AEN=1, MEMR_N=0 -> DB_oe=1, DB_out = mem[addr] registered. A read completes on the MEMR_N rising edge; readCount then increments by 1.
- Write: in GRANT, AEN=1, MEMW_N=0 -> mem[addr] <= DB_in every cycle the strobe is low. writeCount increments once per falling edge of MEMW_N.
- MEMR_N=0 and MEMW_N=0 in the same cycle: no write, DB_oe=0, protocolError set.
- Any strobe low while HLDA=0 or AEN=0: access ignored, protocolError set.
- ADSTB=1 together with MEMR_N=0: protocolError set.
- EOP_N=0 in GRANT sets eopSeen. EOP_N has no effect on HLDA; HRQ alone releases the bus.
- Counters wrap 16'hFFFF -> 0 with no flag.
- protocolError is cleared only by RESET.

## Timing
- Reset values: HLDA=0, DB_oe=0, DB_out=0, eopSeen=0, protocolError=0, readCount=0, writeCount=0, upperAddr=0, FSM=IDLE. Memory contents are not reset.
- RESET mid-grant: HLDA drops asynchronously and does not wait for a clock.
- HRQ-to-HLDA latency with cpuBusy=0 throughout: GRANT_DELAY+1 rising edges from the edge that samples HRQ=1 to HLDA=1.
- HRQ fall to HLDA fall: one cycle (GRANT->RELEASE edge).
- Read data: DB_out valid and DB_oe=1 on the cycle after MEMR_N is first sampled low. DB_oe drops on the cycle after MEMR_N is sampled high.
- Write: memory updated at the edge sampling MEMW_N=0. Read-after-write to the same address in the next strobe returns the new data.
- ADSTB latch effective at the same edge that samples it. An address in that same cycle uses the old upperAddr.

## Structure
- Shared package dma_pkg holds:
  - holdState_t enum (IDLE/WAIT/GRANT/RELEASE, one-hot)
  - DMA_ADDR_W=16 and DATA_W=8 constants
  - strobe decode function isAccess(aen, hlda, memr_n, memw_n)
- One natural sub-module: dma_resp_mem (single-port byte RAM, registered read, ADDR_BITS parameter). Everything else lives in the top module.

## Test plan
- Grant handshake: GRANT_DELAY=2, cpuBusy=0, HRQ rises at cycle 0 -> HLDA=1 at cycle 3. Drop HRQ at cycle 10 -> HLDA=0 at cycle 11.
- CPU contention: HRQ held and cpuBusy=1 for cycles 0-5 -> HLDA stays 0 through cycle 5 and rises at cycle 8.
- Write/read round trip: ADSTB with DB_in=8'h01, A=8'h23, MEMW_N low 2 cycles with DB_in=8'hA5 -> mem[0x123]=A5, writeCount=1. MEMR_N low -> DB_out=A5 with DB_oe=1 the next cycle, readCount=1 after MEMR_N rises.
- Illegal cycles: MEMR_N=MEMW_N=0 in GRANT -> no memory change, DB_oe=0, protocolError=1. MEMW_N low with HLDA=0 -> protocolError=1, no write.
- EOP: EOP_N low one cycle in GRANT -> eopSeen=1 and HLDA unchanged. HRQ drop -> eopSeen=0 in RELEASE.
- Async reset mid-read: RESET asserted between edges while DB_oe=1 -> HLDA=0, DB_oe=0 immediately, counters 0, prior memory data preserved after reset releases.
